// File: rtl/norm_shift_ctrl.sv
// norm_shift_ctrl: left-normalizes an operand by sequencing passes through an external limited-range left shifter
module norm_shift_ctrl #(
    parameter  int N          = 32,
    parameter  int SHIFT_BITS = 4,
    localparam int SHAMT_W    = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [N-1:0]          in_data,
    output logic                  busy,
    output logic                  out_valid,
    output logic [N-1:0]          out_data,
    output logic [SHAMT_W-1:0]    out_shamt,
    output logic                  out_zero,
    output logic                  sh_en,
    output logic [N-1:0]          sh_in,
    output logic [SHIFT_BITS-1:0] sh_count,
    input  logic [N-1:0]          sh_out,
    input  logic                  sh_done
);
    localparam int LZW  = $clog2(N + 1);
    localparam int MAXS = 2 ** SHIFT_BITS - 1;

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                r_state, w_next;
    logic [N-1:0]          r_work;
    logic [SHAMT_W-1:0]    r_acc;
    logic [SHIFT_BITS-1:0] r_sh_count;
    logic [LZW-1:0]        w_lz;
    logic                  w_found;
    logic                  w_zero;

    assign sh_in    = r_work;
    assign sh_count = r_sh_count;
    assign w_zero   = (r_work == '0);

    // Leading-zero count of the working value, scanning down from the MSB
    always_comb begin
        w_lz    = '0;
        w_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!w_found) begin
                if (r_work[i]) w_found = 1'b1;
                else w_lz = w_lz + LZW'(1);
            end
        end
    end

    // State register; reset aborts any pass in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state and Moore output decode
    always_comb begin
        w_next    = r_state;
        busy      = (r_state != S_IDLE);
        sh_en     = (r_state == S_ISSUE);
        out_valid = (r_state == S_DONE);
        case (r_state)
            S_IDLE:  w_next = start ? S_CHECK : S_IDLE;
            S_CHECK: w_next = (w_zero || w_lz == '0) ? S_DONE : S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  w_next = sh_done ? S_CHECK : S_WAIT;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Working value, accumulated shift, pass amount and held results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work     <= '0;
            r_acc      <= '0;
            r_sh_count <= '0;
            out_data   <= '0;
            out_shamt  <= '0;
            out_zero   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_work <= in_data;
                        r_acc  <= '0;
                    end
                end
                S_CHECK: begin
                    if (w_zero) begin
                        out_zero  <= 1'b1;
                        out_shamt <= '0;
                        out_data  <= '0;
                    end else if (w_lz == '0) begin
                        out_zero  <= 1'b0;
                        out_shamt <= r_acc;
                        out_data  <= r_work;
                    end else begin
                        r_sh_count <= (32'(w_lz) > MAXS) ? SHIFT_BITS'(MAXS) : SHIFT_BITS'(w_lz);
                    end
                end
                S_WAIT: begin
                    if (sh_done) begin
                        r_work <= sh_out;
                        r_acc  <= r_acc + SHAMT_W'(r_sh_count);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_norm_shift_ctrl.sv
// tb_norm_shift_ctrl: directed checks of the normalization sequencer against a registered shifter model
module tb_norm_shift_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] in_data = '0;
    logic        busy, out_valid, out_zero, sh_en, sh_done;
    logic [31:0] out_data, sh_in, sh_out;
    logic [4:0]  out_shamt;
    logic [3:0]  sh_count;
    logic        r_done = 1'b0;
    logic        spur = 1'b0;
    logic [31:0] r_out = '0;
    int          tests = 0;
    int          fails = 0;
    logic [3:0]  cnts[$];

    norm_shift_ctrl #(.N(32), .SHIFT_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
        .busy(busy), .out_valid(out_valid), .out_data(out_data),
        .out_shamt(out_shamt), .out_zero(out_zero), .sh_en(sh_en),
        .sh_in(sh_in), .sh_count(sh_count), .sh_out(sh_out), .sh_done(sh_done)
    );

    always #5 clk = ~clk;

    // Registered left shifter: result and done appear the cycle after enable
    always @(posedge clk) begin
        r_done <= sh_en;
        if (sh_en) r_out <= sh_in << sh_count;
    end
    assign sh_out  = r_out;
    assign sh_done = r_done | spur;

    // Record the count presented with every enable cycle
    always @(posedge clk) if (sh_en) cnts.push_back(sh_count);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
    endtask

    task automatic check_res(input string tag, input logic [31:0] ed, input logic [4:0] es, input logic ez);
        chk({tag, ".data"}, out_data, ed);
        chk({tag, ".shamt"}, out_shamt, es);
        chk({tag, ".zero"}, out_zero, ez);
    endtask

    task automatic check_cnts(input string tag, input int np, input logic [3:0] c0, input logic [3:0] c1, input logic [3:0] c2);
        logic [3:0] e[3];
        e = '{c0, c1, c2};
        chk({tag, ".npass"}, cnts.size(), np);
        for (int i = 0; i < np && i < 3; i++)
            chk({tag, ".cnt"}, (i < cnts.size()) ? {60'd0, cnts[i]} : 64'hx, e[i]);
    endtask

    task automatic do_op(input string tag, input logic [31:0] d, input bit sp, input int elat,
                         input logic [31:0] ed, input logic [4:0] es, input logic ez,
                         input int np, input logic [3:0] c0, input logic [3:0] c1, input logic [3:0] c2);
        int lat;
        cnts.delete();
        in_data = d;
        start = 1'b1;
        step();
        start = 1'b0;
        if (sp) spur = 1'b1;
        step();
        spur = 1'b0;
        lat = 2;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
        chk({tag, ".lat"}, lat, elat);
        check_res(tag, ed, es, ez);
        check_cnts(tag, np, c0, c1, c2);
        step();
        chk({tag, ".vpulse"}, out_valid, 1'b0);
        chk({tag, ".idle"}, busy, 1'b0);
    endtask

    initial begin
        int lat;
        bit seen;
        #1;
        chk("rst.busy", busy, 1'b0);
        chk("rst.valid", out_valid, 1'b0);
        chk("rst.sh_en", sh_en, 1'b0);
        chk("rst.outs", {out_data, out_shamt, out_zero}, 38'd0);
        chk("rst.sh", {sh_in, sh_count}, 36'd0);
        step();
        rst_n = 1'b1;
        step();

        do_op("msb", 32'h8000_0000, 1'b0, 2, 32'h8000_0000, 5'd0, 1'b0, 0, 4'd0, 4'd0, 4'd0);
        do_op("one", 32'h0000_0001, 1'b0, 11, 32'h8000_0000, 5'd31, 1'b0, 3, 4'd15, 4'd15, 4'd1);
        do_op("f000", 32'h0000_F000, 1'b0, 8, 32'hF000_0000, 5'd16, 1'b0, 2, 4'd15, 4'd1, 4'd0);
        do_op("zero", 32'h0000_0000, 1'b0, 2, 32'h0000_0000, 5'd0, 1'b1, 0, 4'd0, 4'd0, 4'd0);

        spur = 1'b1;
        step();
        spur = 1'b0;
        chk("spur_idle.busy", busy, 1'b0);
        step();
        chk("spur_idle.still", busy, 1'b0);

        do_op("spur_chk", 32'h00F0_0000, 1'b1, 5, 32'hF000_0000, 5'd8, 1'b0, 1, 4'd8, 4'd0, 4'd0);

        cnts.delete();
        in_data = 32'h0000_F000;
        start = 1'b1;
        step();
        in_data = 32'h0000_0001;
        wait_valid(lat);
        chk("hold.lat", lat, 8);
        check_res("hold", 32'hF000_0000, 5'd16, 1'b0);
        check_cnts("hold", 2, 4'd15, 4'd1, 4'd0);
        step();
        chk("b2b.idle", busy, 1'b0);
        cnts.delete();
        step();
        start = 1'b0;
        chk("b2b.accept", busy, 1'b1);
        wait_valid(lat);
        chk("b2b.lat", lat, 11);
        check_res("b2b", 32'h8000_0000, 5'd31, 1'b0);
        check_cnts("b2b", 3, 4'd15, 4'd15, 4'd1);
        step();

        in_data = 32'h0000_0001;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("mid.wait_busy", busy, 1'b1);
        chk("mid.wait_en", sh_en, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid.busy", busy, 1'b0);
        chk("mid.sh_en", sh_en, 1'b0);
        chk("mid.outs", {out_data, out_shamt, out_zero}, 38'd0);
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (out_valid || busy) seen = 1'b1;
        end
        chk("mid.no_valid", seen, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
